char_present_seq: RTL and testbench

Presentation sequencer for `char_pwm_gen` in the neuromorphic bridge.
- Drives `char_select` through a programmed range of characters.
- Holds each character for a programmed number of cycles with the PWM path enabled, then inserts a programmable rest gap with the path disabled.
- Counts the `digit` spikes emitted during each presentation and reports the total.
- Sits between the host/config logic and `char_pwm_gen`; its spike count feeds the network input monitor.

---
 rtl/char_present_seq_if.sv | 32 +++
 rtl/char_present_seq.sv | 132 +++++++++++++
 tb/tb_char_present_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/char_present_seq_if.sv
// Bus between the host/config side and the character presentation sequencer.
// The host pulses start or abort for one cycle. count_valid and done are one-cycle strobes with no backpressure. Config inputs are sampled only when start is accepted.
interface char_present_seq_if #(
  parameter int HOLD_W = 16,
  parameter int REST_W = 16
);
  logic              start;
  logic              abort;
  logic [HOLD_W-1:0] hold_cycles;
  logic [REST_W-1:0] rest_cycles;
  logic [1:0]        char_first;
  logic [1:0]        char_last;
  logic [3:0]        loops;
  logic              digit;
  logic [1:0]        char_select;
  logic              pwm_en;
  logic              busy;
  logic [HOLD_W-1:0] spike_count;
  logic              count_valid;
  logic              done;
  logic [1:0]        dbg_state;

  modport master (
    output start, abort, hold_cycles, rest_cycles, char_first, char_last, loops, digit,
    input  char_select, pwm_en, busy, spike_count, count_valid, done, dbg_state
  );

  modport slave (
    input  start, abort, hold_cycles, rest_cycles, char_first, char_last, loops, digit,
    output char_select, pwm_en, busy, spike_count, count_valid, done, dbg_state
  );
endinterface

// File: rtl/char_present_seq.sv
// Sweeps char_select over a latched character range, holding each one with PWM enabled,
// optionally resting between characters, and reports the digit spikes counted per presentation.
module char_present_seq #(
  parameter int HOLD_W = 16,
  parameter int REST_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  char_present_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_REST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_m1_q, hcnt_q, acc_q, spike_q;
  logic [REST_W-1:0] rest_q, rcnt_q;
  logic [1:0]        first_q, last_q, cur_q;
  logic [3:0]        rem_q;
  logic              inf_q, cv_q;
  logic              go, hold_end, rest_end, advance, sweep_end, last_loop;

  assign go = bus.start && !bus.abort;

  always_comb begin
    hold_end  = (state_q == S_PRESENT) && (hcnt_q == hold_m1_q);
    rest_end  = (state_q == S_REST) && (rcnt_q == rest_q - REST_W'(1));
    advance   = (hold_end && (rest_q == '0)) || rest_end;
    sweep_end = (cur_q == last_q);
    last_loop = !inf_q && (rem_q == 4'd1);
    state_d   = state_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_PRESENT;
      S_PRESENT: begin
        if (hold_end) begin
          if (rest_q != '0)             state_d = S_REST;
          else if (sweep_end && last_loop) state_d = S_DONE;
          else                          state_d = S_PRESENT;
        end
      end
      S_REST: begin
        if (rest_end) begin
          if (sweep_end && last_loop) state_d = S_DONE;
          else                        state_d = S_PRESENT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_m1_q <= '0;
      hcnt_q    <= '0;
      acc_q     <= '0;
      spike_q   <= '0;
      rest_q    <= '0;
      rcnt_q    <= '0;
      first_q   <= 2'd0;
      last_q    <= 2'd0;
      cur_q     <= 2'd0;
      rem_q     <= 4'd0;
      inf_q     <= 1'b0;
      cv_q      <= 1'b0;
    end else begin
      cv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            hold_m1_q <= (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - HOLD_W'(1);
            rest_q    <= bus.rest_cycles;
            first_q   <= bus.char_first;
            last_q    <= bus.char_last;
            rem_q     <= bus.loops;
            inf_q     <= (bus.loops == 4'd0);
            cur_q     <= bus.char_first;
            hcnt_q    <= '0;
            rcnt_q    <= '0;
            acc_q     <= '0;
          end
        end
        S_PRESENT: begin
          if (hold_end) begin
            hcnt_q <= '0;
            acc_q  <= '0;
            // An abort on the closing cycle discards this presentation's count.
            if (!bus.abort) begin
              spike_q <= acc_q + HOLD_W'(bus.digit);
              cv_q    <= 1'b1;
            end
          end else begin
            hcnt_q <= hcnt_q + HOLD_W'(1);
            acc_q  <= acc_q + HOLD_W'(bus.digit);
          end
        end
        S_REST: begin
          if (rest_end) rcnt_q <= '0;
          else          rcnt_q <= rcnt_q + REST_W'(1);
        end
        default: ;
      endcase
      if (advance && !bus.abort) begin
        if (!sweep_end) begin
          cur_q <= cur_q + 2'd1;
        end else begin
          if (!inf_q)     rem_q <= rem_q - 4'd1;
          if (!last_loop) cur_q <= first_q;
        end
      end
    end
  end

  assign bus.char_select = cur_q;
  assign bus.pwm_en      = (state_q == S_PRESENT);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.spike_count = spike_q;
  assign bus.count_valid = cv_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_char_present_seq.sv
// Bench for char_present_seq: directed table, abort/reset/protocol sequences, and randomized
// runs checked cycle by cycle against a sweep-level reference trace.
module tb_char_present_seq;

  localparam int HW   = 16;
  localparam int RW   = 16;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  char_present_seq_if #(.HOLD_W(HW), .REST_W(RW)) bus ();
  char_present_seq #(.HOLD_W(HW), .REST_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [1:0]    first;
    logic [1:0]    last;
    logic [3:0]    loops;
    logic [HW-1:0] hold;
    logic [RW-1:0] rest;
    int            dmode;
    int            exp_strobes;
    int            exp_done;
    int            exp_spike;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [HW-1:0] exp_q[$];
  logic [HW-1:0] exp_sc;

  logic          m_pwm [MAXC];
  logic          m_busy[MAXC];
  logic          m_cv  [MAXC];
  logic          m_done[MAXC];
  logic [1:0]    m_chr [MAXC];
  logic [HW-1:0] m_sc  [MAXC];
  logic          dig   [MAXC];
  int            m_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference trace: sweeps x characters x (H present cycles + R rest cycles), then DONE.
  task automatic build_model(input int first, input int last, input int sweeps,
                             input int hold, input int rest);
    int h, n, p, sum;
    h = (hold == 0) ? 1 : hold;
    n = ((last - first + 4) % 4) + 1;
    for (int i = 0; i < MAXC; i++) begin
      m_pwm[i] = 0; m_busy[i] = 0; m_cv[i] = 0; m_done[i] = 0;
      m_chr[i] = 2'(last); m_sc[i] = '0;
    end
    p = 1;
    for (int s = 0; s < sweeps; s++) begin
      for (int i = 0; i < n; i++) begin
        sum = 0;
        for (int c = 0; c < h; c++) begin
          m_pwm[p] = 1; m_busy[p] = 1; m_chr[p] = 2'((first + i) % 4);
          sum += int'(dig[p]);
          p++;
        end
        m_cv[p] = 1;
        m_sc[p] = HW'(sum);
        for (int r = 0; r < rest; r++) begin
          m_busy[p] = 1; m_chr[p] = 2'((first + i) % 4);
          p++;
        end
      end
    end
    m_done[p] = 1;
    m_busy[p] = 1;
    m_len = p;
  endtask

  // abort_at: 0 none, -1 random cycle inside the run, >0 that cycle.
  task automatic run_case(input int first, input int last, input int loops, input int hold,
                          input int rest, input int dmode, input int abort_at, input bit scramble,
                          output int strobes, output int done_at, output int sc_min, output int sc_max);
    int n_cyc, ab;
    logic [HW-1:0] e;
    strobes = 0; done_at = 0; sc_min = 1 << 30; sc_max = -1;
    for (int j = 0; j < MAXC; j++)
      dig[j] = (dmode == 0) ? 1'b1 : (dmode == 1) ? 1'(j % 2) : 1'($urandom_range(0, 1));
    build_model(first, last, (loops == 0) ? 4 : loops, hold, rest);
    ab = (abort_at < 0) ? int'($urandom_range(1, m_len - 1)) : abort_at;
    if (ab > 0) begin
      for (int p = ab + 1; p < MAXC; p++) begin
        m_busy[p] = 0; m_pwm[p] = 0; m_cv[p] = 0; m_done[p] = 0; m_chr[p] = m_chr[ab];
      end
      n_cyc = ab + 4;
    end else begin
      n_cyc = m_len + 3;
    end
    exp_q.delete();
    for (int p = 1; p <= n_cyc; p++) if (m_cv[p]) exp_q.push_back(m_sc[p]);

    @(negedge clk);
    bus.char_first = 2'(first); bus.char_last = 2'(last); bus.loops = 4'(loops);
    bus.hold_cycles = HW'(hold); bus.rest_cycles = RW'(rest);
    bus.start = 1'b1; bus.abort = 1'b0; bus.digit = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.digit = dig[1];
    bus.abort = (ab == 1);
    for (int j = 1; j <= n_cyc; j++) begin
      @(negedge clk);
      check($sformatf("pwm_en@%0d", j), bus.pwm_en, m_pwm[j]);
      check($sformatf("busy@%0d", j), bus.busy, m_busy[j]);
      check($sformatf("char_select@%0d", j), bus.char_select, m_chr[j]);
      check($sformatf("done@%0d", j), bus.done, m_done[j]);
      if (bus.done) done_at = j;
      if (bus.count_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          exp_sc = e;
          strobes++;
          if (int'(bus.spike_count) < sc_min) sc_min = int'(bus.spike_count);
          if (int'(bus.spike_count) > sc_max) sc_max = int'(bus.spike_count);
        end else begin
          check($sformatf("spurious_strobe@%0d", j), bus.count_valid, 1'b0);
        end
      end
      check($sformatf("count_valid@%0d", j), bus.count_valid, m_cv[j]);
      check($sformatf("spike_count@%0d", j), bus.spike_count, exp_sc);
      @(posedge clk);
      #1;
      bus.digit = dig[j + 1];
      bus.abort = (j + 1 == ab);
      if (scramble) begin
        bus.hold_cycles = HW'($urandom_range(0, 20));
        bus.rest_cycles = RW'($urandom_range(0, 6));
        bus.char_first  = 2'($urandom_range(0, 3));
        bus.char_last   = 2'($urandom_range(0, 3));
        bus.loops       = 4'($urandom_range(0, 15));
        bus.start       = m_busy[j + 1] && ($urandom_range(0, 3) == 0);
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("strobes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int st, da, mn, mx;
    tbl[0] = '{first:2'd0, last:2'd3, loops:4'd1, hold:16'd8,  rest:16'd4, dmode:0, exp_strobes:4, exp_done:49, exp_spike:8};
    tbl[1] = '{first:2'd3, last:2'd1, loops:4'd2, hold:16'd5,  rest:16'd0, dmode:0, exp_strobes:6, exp_done:31, exp_spike:5};
    tbl[2] = '{first:2'd0, last:2'd0, loops:4'd1, hold:16'd10, rest:16'd2, dmode:1, exp_strobes:1, exp_done:13, exp_spike:5};
    tbl[3] = '{first:2'd2, last:2'd2, loops:4'd1, hold:16'd0,  rest:16'd0, dmode:0, exp_strobes:1, exp_done:2,  exp_spike:1};
    tbl[4] = '{first:2'd2, last:2'd2, loops:4'd3, hold:16'd3,  rest:16'd1, dmode:1, exp_strobes:3, exp_done:13, exp_spike:2};

    bus.start = 0; bus.abort = 0; bus.hold_cycles = '0; bus.rest_cycles = '0;
    bus.char_first = 0; bus.char_last = 0; bus.loops = 0; bus.digit = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_char_select", bus.char_select, 0);
    check("rst_pwm_en", bus.pwm_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_spike_count", bus.spike_count, 0);
    check("rst_count_valid", bus.count_valid, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    exp_sc = '0;
    @(negedge clk);
    check("idle_after_reset", bus.busy, 0);

    for (int t = 0; t < 5; t++) begin
      run_case(int'(tbl[t].first), int'(tbl[t].last), int'(tbl[t].loops), int'(tbl[t].hold),
               int'(tbl[t].rest), tbl[t].dmode, 0, 1'b0, st, da, mn, mx);
      check($sformatf("tbl%0d_strobes", t), st, tbl[t].exp_strobes);
      check($sformatf("tbl%0d_done_cycle", t), da, tbl[t].exp_done);
      check($sformatf("tbl%0d_spike_min", t), mn, tbl[t].exp_spike);
      check($sformatf("tbl%0d_spike_max", t), mx, tbl[t].exp_spike);
    end

    // start together with abort in IDLE must not launch a run
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.loops = 4'd1; bus.hold_cycles = 16'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("start_abort_busy@%0d", j), bus.busy, 0);
      check($sformatf("start_abort_pwm@%0d", j), bus.pwm_en, 0);
    end

    // abort in the third PRESENT cycle of char 1 on an endless run
    run_case(0, 3, 0, 6, 2, 0, 11, 1'b0, st, da, mn, mx);
    check("abort_strobes", st, 1);
    check("abort_no_done", da, 0);
    run_case(2, 2, 1, 2, 0, 0, 0, 1'b0, st, da, mn, mx);
    check("restart_done_cycle", da, 3);
    check("restart_spike", mx, 2);

    for (int r = 0; r < 14; r++) begin
      int lp;
      lp = int'($urandom_range(0, 3));
      run_case(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lp,
               int'($urandom_range(0, 12)), int'($urandom_range(0, 5)), 2,
               (lp == 0 || $urandom_range(0, 2) == 0) ? -1 : 0, 1'b1, st, da, mn, mx);
    end

    // asynchronous reset during REST
    @(negedge clk);
    bus.char_first = 2'd1; bus.char_last = 2'd3; bus.loops = 4'd1;
    bus.hold_cycles = 16'd4; bus.rest_cycles = 16'd3; bus.digit = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_char_select", bus.char_select, 1);
    check("pre_rst_pwm_en", bus.pwm_en, 0);
    check("pre_rst_spike_count", bus.spike_count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_char_select", bus.char_select, 0);
    check("async_rst_pwm_en", bus.pwm_en, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_spike_count", bus.spike_count, 0);
    check("async_rst_count_valid", bus.count_valid, 0);
    check("async_rst_done", bus.done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("post_rst_busy@%0d", j), bus.busy, 0);
      check($sformatf("post_rst_state@%0d", j), bus.dbg_state, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
